muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences RV32M multiply/divide ops for the Execute stage over several cycles
//  with a shift-add multiplier and a restoring divider. Execute asserts start_i
//  while an M-op sits in its input registers. The block stalls the pipe and
//  returns one XLEN-bit result per op, held until the Memory stage accepts it.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk_i           in   1     clock, rising edge
//  rst_i           in   1     reset, asynchronous, active-high
//  start_i         in   1     M-op present in Execute (level, held while stall_o=1)
//  op_i            in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  operand_a_i     in   XLEN  rs1 value
//  operand_b_i     in   XLEN  rs2 value
//  flush_i         in   1     abort current op (branch/jump flush)
//  mem_ready_i     in   1     Memory stage accepts result this cycle
//  stall_o         out  1     hold Execute/Decode; = start_i & ~(state==DONE & mem_ready_i)
//  busy_o          out  1     state is RUN or DONE
//  result_valid_o  out  1     state==DONE
//  result_o        out  XLEN  final result; valid only while result_valid_o=1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, count=0, result_o=0, busy_o=0, result_valid_o=0.
//   stall_o follows start_i (comb). Reset mid-op discards the op; nothing is returned.
//  States: IDLE -> RUN -> DONE -> IDLE; IDLE -> DONE (fast path).
//  IDLE: start_i=1 & flush_i=0 at edge E: latch op, abs operands (signed per op),
//   sign flags. Fast path -> DONE at E: divisor 0 (quotient all-ones, remainder =
//   operand_a_i); signed overflow DIV/REM with a=100..0, b=-1 (q=a, r=0).
//   Otherwise load count=XLEN-1 -> RUN.
//  RUN: one bit per cycle. MUL: 2*XLEN-bit accumulator, add multiplicand if LSB set,
//   shift right. DIV: restoring shift/subtract; quotient bit = ~borrow.
//   count==0 -> DONE; result_o written with sign correction applied in that edge.
//  Latency: accept edge E -> result_valid_o first high in the cycle after edge E+XLEN
//   (XLEN+1 cycles of stall); fast path: cycle after E.
//  DONE: result_o stable. mem_ready_i=1 -> IDLE (stall_o drops same cycle, so Execute
//   advances). mem_ready_i=0 -> hold DONE, stall_o=1.
//  Result select: MUL low XLEN of product; MULH/MULHSU/MULHU high XLEN.
//   MULHSU: only a is signed. DIV/DIVU quotient; REM/REMU remainder.
//   Signed negation: product neg if sign_a^sign_b. Quotient neg if sign_a^sign_b;
//   remainder takes sign of a. Signed divide truncates toward zero.
//  flush_i=1: any state -> IDLE next edge; result discarded. flush_i beats start_i in IDLE.
//  Simultaneous DONE & mem_ready_i & new start_i: go to IDLE first. The new op is
//   accepted no earlier than the following cycle (1 idle cycle between ops).
//  op_i/operands ignored outside IDLE (latched copies used).
//  Counter: log2(XLEN) bits, no wrap; leaves RUN exactly at count 0.
// TESTING
//  1 MUL 7*6, mem_ready_i=1 -> result_o=42, result_valid_o at E+33, stall_o high 33 cycles
//  2 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
//  3 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; all valid at E+1
//  4 MUL done, mem_ready_i=0 for 5 cycles -> DONE held, result stable, stall_o=1;
//    then ready=1 -> IDLE
//  5 flush_i at RUN count=10 -> IDLE next cycle, no result_valid_o. rst_i pulse mid-RUN
//    -> outputs 0 at once
//  6 back-to-back MULH(-2,3)=0xFFFFFFFF then DIVU(100,7)=14 -> both correct, 1 idle cycle between

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide: shift-add multiplier, restoring divider, one bit per cycle.
// Latency XLEN+1 stall cycles (one for the fast path); result held in DONE until mem_ready_i.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    input  logic            mem_ready_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_result;

    // Input decode, only meaningful while IDLE
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_neg_in;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_accept;

    assign w_is_div   = op_i[2];
    assign w_a_signed = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_b_signed = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_sign_a   = w_a_signed & operand_a_i[XLEN-1];
    assign w_sign_b   = w_b_signed & operand_b_i[XLEN-1];
    assign w_abs_a    = w_sign_a ? (-operand_a_i) : operand_a_i;
    assign w_abs_b    = w_sign_b ? (-operand_b_i) : operand_b_i;
    // Remainder follows the dividend's sign; product and quotient follow sign_a ^ sign_b
    assign w_neg_in   = (op_i == OP_REM) ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_div_zero = w_is_div & (operand_b_i == '0);
    assign w_ovf      = ((op_i == OP_DIV) | (op_i == OP_REM))
                      & (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                      & (operand_b_i == '1);
    assign w_fast     = w_div_zero | w_ovf;
    assign w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = op_i[1] ? operand_a_i : '1;
        end else if (w_ovf) begin
            w_fast_res = op_i[1] ? '0 : operand_a_i;
        end
    end

    // One iteration: multiplier uses acc = {partial_hi, multiplier}, divider uses {remainder, dividend/quotient}
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_shift;
    logic              w_borrow;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [2*XLEN-1:0] w_step;

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    assign w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_borrow  = (w_shift < {1'b0, r_mcand});
    assign w_diff    = w_shift[XLEN-1:0] - r_mcand;
    assign w_rem_nxt = w_borrow ? w_shift[XLEN-1:0] : w_diff;
    assign w_div_nxt = {w_rem_nxt, r_acc[XLEN-2:0], ~w_borrow};

    assign w_step    = r_op[2] ? w_div_nxt : w_mul_nxt;

    // Sign correction applied on the final iteration's value
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_prod_fix = r_neg ? (-w_step) : w_step;
    assign w_quo      = w_step[XLEN-1:0];
    assign w_rem      = w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = r_neg ? (-w_quo) : w_quo;
            OP_REM, OP_REMU:              w_final = r_neg ? (-w_rem) : w_rem;
            default:                      w_final = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    w_state_nxt = w_fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || mem_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= op_i;
            r_neg   <= w_neg_in;
            r_mcand <= w_is_div ? w_abs_b : w_abs_a;
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_count <= CNT_INIT;
            if (w_fast) begin
                r_result <= w_fast_res;
            end
        end else if ((r_state == S_RUN) && !flush_i) begin
            r_acc <= w_step;
            if (r_count == '0) begin
                r_result <= w_final;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign busy_o         = (r_state != S_IDLE);
    assign result_valid_o = (r_state == S_DONE);
    assign result_o       = r_result;
    assign stall_o        = start_i & ~((r_state == S_DONE) & mem_ready_i);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            mem_ready_i;
    logic            stall_o;
    logic            busy_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .op_i           (op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .flush_i        (flush_i),
        .mem_ready_i    (mem_ready_i),
        .stall_o        (stall_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p_ss;
        logic [63:0]        p_su;
        logic [63:0]        p_uu;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa   = a;
        sb   = b;
        p_ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        p_su = {{32{a[31]}}, a} * {32'h0, b};
        p_uu = {32'h0, a} * {32'h0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return p_uu[31:0];
            3'd1: return p_ss[63:32];
            3'd2: return p_su[63:32];
            3'd3: return p_uu[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Presents an op, waits for the result, holds DONE for 'delay' cycles, then accepts it.
    // Returns in the IDLE cycle that follows acceptance with start_i still asserted.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int delay);
        int k;
        int stalls;
        int lat;
        lat         = is_fast(op, a, b) ? 1 : XLEN + 1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        start_i     = 1'b1;
        mem_ready_i = (delay == 0);
        #1;
        check({tag, ":stall_pre"}, 32'(stall_o), 32'd1);
        stalls = 1;
        k      = 0;
        do begin
            tick();
            k++;
            if (!result_valid_o) begin
                if (stall_o) stalls++;
                op_i        = 3'($urandom);
                operand_a_i = $urandom;
                operand_b_i = $urandom;
            end
        end while (!result_valid_o && k < 100);
        check({tag, ":latency"}, 32'(k), 32'(lat));
        check({tag, ":stall_cycles"}, 32'(stalls), 32'(lat));
        check({tag, ":result"}, result_o, exp);
        for (int i = 0; i < delay; i++) begin
            check({tag, ":hold_valid"}, 32'(result_valid_o), 32'd1);
            check({tag, ":hold_stall"}, 32'(stall_o), 32'd1);
            check({tag, ":hold_result"}, result_o, exp);
            tick();
        end
        mem_ready_i = 1'b1;
        #1;
        check({tag, ":stall_release"}, 32'(stall_o), 32'd0);
        tick();
        check({tag, ":idle_busy"}, 32'(busy_o), 32'd0);
        check({tag, ":idle_valid"}, 32'(result_valid_o), 32'd0);
    endtask

    initial begin
        int          nvalid;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;

        rst_i       = 1'b1;
        start_i     = 1'b1;
        flush_i     = 1'b0;
        mem_ready_i = 1'b0;
        op_i        = '0;
        operand_a_i = '0;
        operand_b_i = '0;
        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_valid", 32'(result_valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_stall_follows_start", 32'(stall_o), 32'd1);
        start_i = 1'b0;
        #1;
        check("reset_stall_low", 32'(stall_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();

        run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 0);
        start_i = 1'b0; tick();
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        start_i = 1'b0; tick();
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        start_i = 1'b0; tick();
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        start_i = 1'b0; tick();
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        start_i = 1'b0; tick();
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
        start_i = 1'b0; tick();
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        start_i = 1'b0; tick();
        run_op("mul_hold5", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 5);
        start_i = 1'b0; tick();
        run_op("b2b_mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0);
        run_op("b2b_divu", 3'd5, 32'd100, 32'd7, 32'd14, 0);
        start_i = 1'b0; tick();

        // Flush while RUN with count at 10
        op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd5;
        start_i = 1'b1; mem_ready_i = 1'b1;
        repeat (22) tick();
        check("flush_pre_busy", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        start_i = 1'b0;
        tick();
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_valid", 32'(result_valid_o), 32'd0);
        nvalid = 0;
        repeat (40) begin
            tick();
            if (result_valid_o) nvalid++;
        end
        check("flush_no_result", 32'(nvalid), 32'd0);

        // Flush has priority over start while IDLE
        op_i = 3'd5; operand_a_i = 32'd9; operand_b_i = 32'd0;
        start_i = 1'b1; flush_i = 1'b1;
        tick();
        check("flush_beats_start_busy", 32'(busy_o), 32'd0);
        check("flush_beats_start_valid", 32'(result_valid_o), 32'd0);
        flush_i = 1'b0; start_i = 1'b0;
        tick();

        // Asynchronous reset mid-RUN
        op_i = 3'd0; operand_a_i = $urandom; operand_b_i = $urandom;
        start_i = 1'b1;
        repeat (10) tick();
        check("rst_pre_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy_o), 32'd0);
        check("rst_async_valid", 32'(result_valid_o), 32'd0);
        check("rst_async_result", result_o, 32'd0);
        start_i = 1'b0;
        #1;
        check("rst_stall_follows_start", 32'(stall_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        for (int n = 0; n < 40; n++) begin
            rop  = 3'($urandom);
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, ref_model(rop, ra, rb),
                   $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                start_i = 1'b0;
                tick();
            end
        end
        start_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
